bus_mux_arbiter: RTL and testbench
==================================

# bus_mux_arbiter

Merges four source buses onto one registered output bus using a valid/ready handshake and round-robin arbitration. Each transfer carries a 2-bit source tag on SEL, so a downstream 1-to-4 bus demultiplexer can route it back by the same encoding. The block sits on the merge side of a fan-out/fan-in pair and provides one output beat per cycle at full throughput.

## Interface
- BUS_WIDTH, 8, width of every data bus.
- CLK  input  1  sole clock; all state updates on the rising edge.
- RST_N  input  1  reset, asynchronous assertion, active-low.
- A, B, C, D  input  BUS_WIDTH each  source data buses, tagged 0, 1, 2, 3 respectively.
- A_VALID, B_VALID, C_VALID, D_VALID  input  1 each  the source holds a beat.
- A_READY, B_READY, C_READY, D_READY  output  1 each  the beat is accepted this cycle.
- Y  output  BUS_WIDTH  registered output data.
- SEL  output  2  registered source tag of Y (0=A, 1=B, 2=C, 3=D).
- Y_VALID  output  1  Y/SEL hold a beat.
- Y_READY  input  1  the sink accepts the beat this cycle.

## Operation
- A transfer occurs on any port when VALID and READY are both high at a rising edge.
- A source must hold its data stable and keep VALID high until it is accepted. VALID must not depend on READY.
- LOAD = !Y_VALID || Y_READY. This means the output register is empty or is draining this cycle.
- Arbitration is combinational over the four VALIDs. Search order starts at the source after LAST (the last granted tag), then wraps modulo 4.
- GNT is the first requesting source in that order. Only GNT's READY may be high, and only when LOAD is high. All other READYs are 0.
- On a transfer from source i: Y <= bus i, SEL <= i, Y_VALID <= 1, LAST <= i.
- If Y_READY is high with no input transfer, Y_VALID <= 0. Y and SEL hold their last values.
- If Y_VALID is high and Y_READY is low, Y, SEL and Y_VALID are held exactly and all READYs are 0.
- If no VALID is high, LAST is unchanged.
- READY outputs depend combinationally on Y_READY and the VALIDs. There is no combinational path from the source data buses to any output.

## Timing
- Reset values: Y=0, SEL=0, Y_VALID=0, LAST=3 (so A has first priority), all READY=0 while RST_N is low.
- Latency: a beat accepted at edge n appears on Y/SEL/Y_VALID after edge n.
- Throughput: one beat per cycle when the sink holds Y_READY high continuously.
- Fairness: with all four sources continuously valid, grants run A, B, C, D, A, ...
- Wrap-around: after LAST=3, the search begins at A.
- Drain and load in the same cycle: the new beat replaces the old one with no bubble, and Y_VALID stays 1.
- Reset asserted mid-transfer: outputs return to reset values immediately and any held beat is discarded. The first edge after release behaves as after power-up.

## Configuration
- BUS_MUX_FIXED_PRIO_EN defined: fixed priority A > B > C > D. LAST is not implemented and the search always starts at A. All other behaviour is unchanged.
- Not defined (default): round-robin arbitration as described above.

## Test plan
- Reset: drive RST_N=0 mid-stream with Y_VALID=1 -> Y=0, SEL=0, Y_VALID=0 asynchronously, and all READY=0.
- Single source: B_VALID=1 with B=8'h5A and Y_READY=1 -> B_READY=1 that cycle; the next cycle shows Y=8'h5A, SEL=1, Y_VALID=1.
- Round-robin: all four VALIDs held high with data 8'h11/22/33/44 and Y_READY=1 -> SEL sequence 0,1,2,3,0,1 on consecutive cycles, with no bubbles.
- Backpressure: Y_VALID=1, Y_READY=0 for 5 cycles with A_VALID=1 -> A_READY=0 throughout and Y/SEL unchanged. On Y_READY=1, A is accepted in that same cycle.
- Skip idle sources: LAST=0, only D_VALID and B_VALID high -> B is granted first, then D, then B.
- Fixed-priority build (BUS_MUX_FIXED_PRIO_EN defined): A and C continuously valid -> SEL=0 every cycle and C is never granted.

Source files
------------

// File: rtl/bus_mux_arbiter.sv
// Four-to-one valid/ready bus merger with a registered output stage and a 2-bit source tag.
// Round-robin by default; define BUS_MUX_FIXED_PRIO_EN for fixed priority A > B > C > D.
module bus_mux_arbiter #(
    parameter int BUS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BUS_WIDTH-1:0] a,
    input  logic [BUS_WIDTH-1:0] b,
    input  logic [BUS_WIDTH-1:0] c,
    input  logic [BUS_WIDTH-1:0] d,
    input  logic                 a_valid,
    input  logic                 b_valid,
    input  logic                 c_valid,
    input  logic                 d_valid,
    output logic                 a_ready,
    output logic                 b_ready,
    output logic                 c_ready,
    output logic                 d_ready,
    output logic [BUS_WIDTH-1:0] y,
    output logic [1:0]           sel,
    output logic                 y_valid,
    input  logic                 y_ready
);

    logic [BUS_WIDTH-1:0] y_r;
    logic [1:0]           sel_r;
    logic                 y_valid_r;
    logic [3:0]           req_s;
    logic [1:0]           start_s;
    logic [2:0]           pick_s;
    logic                 load_s;
    logic                 xfer_s;
    logic [3:0]           ready_s;
    logic [BUS_WIDTH-1:0] data_s;

    // Returns {found, index} of the first set request at or after start, wrapping modulo 4.
    function automatic logic [2:0] first_req(input logic [3:0] req, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            res = req[idx] ? {1'b1, idx} : res;
        end
        return res;
    endfunction

`ifdef BUS_MUX_FIXED_PRIO_EN
    assign start_s = 2'd0;
`else
    logic [1:0] last_r;

    assign start_s = last_r + 2'd1;

    // Remembers the most recently granted source; only moves on an actual transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r <= 2'd3;
        end else if (xfer_s) begin
            last_r <= pick_s[1:0];
        end else begin
            last_r <= last_r;
        end
    end
`endif

    assign req_s  = {d_valid, c_valid, b_valid, a_valid};
    assign pick_s = first_req(req_s, start_s);
    assign load_s = !y_valid_r || y_ready;
    // READY is forced low while reset is held, even though the output stage then looks empty.
    assign xfer_s = rst_n && load_s && pick_s[2];

    // Grant decode and data selection for the winning source.
    always_comb begin
        ready_s = 4'b0000;
        data_s  = {BUS_WIDTH{1'b0}};
        if (xfer_s) begin
            ready_s = 4'b0001 << pick_s[1:0];
        end else begin
            ready_s = 4'b0000;
        end
        case (pick_s[1:0])
            2'd0:    data_s = a;
            2'd1:    data_s = b;
            2'd2:    data_s = c;
            2'd3:    data_s = d;
            default: data_s = {BUS_WIDTH{1'b0}};
        endcase
    end

    // Output register: load on transfer, drop valid on drain, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_r       <= {BUS_WIDTH{1'b0}};
            sel_r     <= 2'd0;
            y_valid_r <= 1'b0;
        end else if (xfer_s) begin
            y_r       <= data_s;
            sel_r     <= pick_s[1:0];
            y_valid_r <= 1'b1;
        end else if (y_ready) begin
            y_r       <= y_r;
            sel_r     <= sel_r;
            y_valid_r <= 1'b0;
        end else begin
            y_r       <= y_r;
            sel_r     <= sel_r;
            y_valid_r <= y_valid_r;
        end
    end

    assign a_ready = ready_s[0];
    assign b_ready = ready_s[1];
    assign c_ready = ready_s[2];
    assign d_ready = ready_s[3];
    assign y       = y_r;
    assign sel     = sel_r;
    assign y_valid = y_valid_r;

endmodule

// File: tb/tb_bus_mux_arbiter.sv
// Directed bench for bus_mux_arbiter; expectations follow BUS_MUX_FIXED_PRIO_EN when defined.
module tb_bus_mux_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] a, b, c, d;
    logic       a_valid, b_valid, c_valid, d_valid;
    logic       a_ready, b_ready, c_ready, d_ready;
    logic [7:0] y;
    logic [1:0] sel;
    logic       y_valid;
    logic       y_ready;

    int total_cnt;
    int bad_cnt;

    logic [7:0] dat [4];
    int exp_rr [6];
    int exp_skip [3];
    int exp_ac [4];

    bus_mux_arbiter #(.BUS_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .a(a), .b(b), .c(c), .d(d),
        .a_valid(a_valid), .b_valid(b_valid), .c_valid(c_valid), .d_valid(d_valid),
        .a_ready(a_ready), .b_ready(b_ready), .c_ready(c_ready), .d_ready(d_ready),
        .y(y), .sel(sel), .y_valid(y_valid), .y_ready(y_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rdy_vec();
        return {28'd0, d_ready, c_ready, b_ready, a_ready};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33; dat[3] = 8'h44;
`ifdef BUS_MUX_FIXED_PRIO_EN
        exp_rr   = '{0, 0, 0, 0, 0, 0};
        exp_skip = '{1, 1, 1};
        exp_ac   = '{0, 0, 0, 0};
`else
        exp_rr   = '{0, 1, 2, 3, 0, 1};
        exp_skip = '{1, 3, 1};
        exp_ac   = '{2, 0, 2, 0};
`endif
        rst_n = 1'b0;
        a = 8'h11; b = 8'h5A; c = 8'h33; d = 8'h44;
        a_valid = 1'b1; b_valid = 1'b0; c_valid = 1'b0; d_valid = 1'b0;
        y_ready = 1'b1;
        #2;
        check_val("rst_y", y, 32'h0);
        check_val("rst_sel", sel, 32'h0);
        check_val("rst_yv", y_valid, 32'h0);
        check_val("rst_rdy", rdy_vec(), 32'h0);
        a_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // single source B
        b_valid = 1'b1;
        #1 check_val("single_rdy", rdy_vec(), 32'h2);
        @(posedge clk); #1;
        check_val("single_y", y, 32'h5A);
        check_val("single_sel", sel, 32'h1);
        check_val("single_yv", y_valid, 32'h1);

        // reset mid-stream with a held beat
        y_ready = 1'b0;
        #1 check_val("hold_rdy", rdy_vec(), 32'h0);
        #1 rst_n = 1'b0;
        #1;
        check_val("midrst_y", y, 32'h0);
        check_val("midrst_sel", sel, 32'h0);
        check_val("midrst_yv", y_valid, 32'h0);
        y_ready = 1'b1;
        #1 check_val("midrst_rdy", rdy_vec(), 32'h0);
        b_valid = 1'b0;
        b = 8'h22;
        @(negedge clk) rst_n = 1'b1;

        // all four sources valid: fairness, wrap-around, no bubbles
        a_valid = 1'b1; b_valid = 1'b1; c_valid = 1'b1; d_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1 check_val($sformatf("rr_rdy%0d", i), rdy_vec(), 32'd1 << exp_rr[i]);
            @(posedge clk); #1;
            check_val($sformatf("rr_sel%0d", i), sel, 32'(exp_rr[i]));
            check_val($sformatf("rr_y%0d", i), y, 32'(dat[exp_rr[i]]));
            check_val($sformatf("rr_yv%0d", i), y_valid, 32'h1);
        end

        // backpressure: only A valid, sink stalled
        b_valid = 1'b0; c_valid = 1'b0; d_valid = 1'b0;
        y_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 check_val($sformatf("bp_rdy%0d", i), rdy_vec(), 32'h0);
            @(posedge clk); #1;
            check_val($sformatf("bp_sel%0d", i), sel, 32'(exp_rr[5]));
            check_val($sformatf("bp_y%0d", i), y, 32'(dat[exp_rr[5]]));
            check_val($sformatf("bp_yv%0d", i), y_valid, 32'h1);
        end
        y_ready = 1'b1;
        #1 check_val("bp_release_rdy", rdy_vec(), 32'h1);
        @(posedge clk); #1;
        check_val("bp_release_sel", sel, 32'h0);
        check_val("bp_release_y", y, 32'h11);

        // skip idle sources: only B and D valid
        a_valid = 1'b0; b_valid = 1'b1; d_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check_val($sformatf("skip_rdy%0d", i), rdy_vec(), 32'd1 << exp_skip[i]);
            @(posedge clk); #1;
            check_val($sformatf("skip_sel%0d", i), sel, 32'(exp_skip[i]));
            check_val($sformatf("skip_y%0d", i), y, 32'(dat[exp_skip[i]]));
        end

        // drain with no new request: valid drops, data and tag hold
        b_valid = 1'b0; d_valid = 1'b0;
        #1 check_val("drain_rdy", rdy_vec(), 32'h0);
        @(posedge clk); #1;
        check_val("drain_yv", y_valid, 32'h0);
        check_val("drain_y", y, 32'h22);
        check_val("drain_sel", sel, 32'h1);

        // A and C continuously valid
        a_valid = 1'b1; c_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 check_val($sformatf("ac_rdy%0d", i), rdy_vec(), 32'd1 << exp_ac[i]);
            @(posedge clk); #1;
            check_val($sformatf("ac_sel%0d", i), sel, 32'(exp_ac[i]));
            check_val($sformatf("ac_yv%0d", i), y_valid, 32'h1);
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
